// File: rtl/ids_bus_xbar.sv
// ids_bus_xbar -- N_MST x N_SLV request/response crossbar for the IDS SoC bus.
//
// Each master's address is decoded on addr[31:28] against a per-slave tag
// (lowest-index match wins). Every slave arbitrates its own requesters
// independently, so masters targeting different slaves are granted in the
// same cycle. Requests to unmapped addresses are granted at once and answered
// with an error pulse (plus zero read data for reads) one cycle later.
// Mapped reads return i_s_dout of the addressed slave exactly one cycle after
// the grant.
//
// Build option: define IDS_BUS_XBAR_RR_EN for round-robin arbitration per
// slave (one pointer per slave). Without it, fixed priority applies (lowest
// master index wins) and no pointer state exists.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_m_req / o_m_gnt         per-master request / combinational grant
//   i_m_addr, i_m_write, i_m_read, i_m_size, i_m_din   master request fields
//   o_m_dout, o_m_rvalid, o_m_err                      master response
//   o_s_addr, o_s_write, o_s_read, o_s_size, o_s_din   slave request side
//   i_s_dout                  slave read data, valid one cycle after o_s_read
module ids_bus_xbar #(
    parameter int                 N_MST   = 2,
    parameter int                 N_SLV   = 3,
    parameter int                 DW      = 32,
    parameter logic [4*N_SLV-1:0] SLV_TAG = {4'h4, 4'h8, 4'h0}
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_MST-1:0]      i_m_req,
    output logic [N_MST-1:0]      o_m_gnt,
    input  logic [N_MST*32-1:0]   i_m_addr,
    input  logic [N_MST-1:0]      i_m_write,
    input  logic [N_MST-1:0]      i_m_read,
    input  logic [N_MST*4-1:0]    i_m_size,
    input  logic [N_MST*DW-1:0]   i_m_din,
    output logic [N_MST*DW-1:0]   o_m_dout,
    output logic [N_MST-1:0]      o_m_rvalid,
    output logic [N_MST-1:0]      o_m_err,
    output logic [N_SLV*32-1:0]   o_s_addr,
    output logic [N_SLV-1:0]      o_s_write,
    output logic [N_SLV-1:0]      o_s_read,
    output logic [N_SLV*4-1:0]    o_s_size,
    output logic [N_SLV*DW-1:0]   o_s_din,
    input  logic [N_SLV*DW-1:0]   i_s_dout
);

    localparam int MW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    // Address decode: iterate downwards so the lowest matching slave wins.
    logic [N_MST-1:0] m_mapped;
    logic [SW-1:0]    m_slv [N_MST];

    always_comb begin
        for (int m = 0; m < N_MST; m++) begin
            m_mapped[m] = 1'b0;
            m_slv[m]    = '0;
            for (int s = N_SLV - 1; s >= 0; s--) begin
                if (i_m_addr[m*32+28 +: 4] == SLV_TAG[s*4 +: 4]) begin
                    m_mapped[m] = 1'b1;
                    m_slv[m]    = SW'(s);
                end
            end
        end
    end

    // Per-slave one-hot grant vectors, flattened as [slave][master].
    logic [N_SLV*N_MST-1:0] slv_gnt;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLV; gi++) begin : g_slv
            logic [N_MST-1:0] req_vec;
            logic [N_MST-1:0] win_oh;
            logic [MW-1:0]    win_idx;
            logic             win_any;

            always_comb begin
                req_vec = '0;
                for (int m = 0; m < N_MST; m++) begin
                    req_vec[m] = i_m_req[m] & m_mapped[m] & (m_slv[m] == SW'(gi));
                end
            end

`ifdef IDS_BUS_XBAR_RR_EN
            logic [MW-1:0] ptr_reg;
            logic [MW-1:0] ptr_next;

            // Search starts at ptr_reg; descending offset so the smallest
            // offset from the pointer is the one that sticks.
            always_comb begin
                int cand;
                win_any = 1'b0;
                win_idx = '0;
                for (int off = N_MST - 1; off >= 0; off--) begin
                    cand = int'(ptr_reg) + off;
                    if (cand >= N_MST) begin
                        cand = cand - N_MST;
                    end
                    if (req_vec[cand]) begin
                        win_any = 1'b1;
                        win_idx = MW'(cand);
                    end
                end
            end

            always_comb begin
                ptr_next = ptr_reg;
                if (win_any) begin
                    ptr_next = (int'(win_idx) == N_MST - 1) ? '0 : win_idx + 1'b1;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    ptr_reg <= '0;
                end else begin
                    ptr_reg <= ptr_next;
                end
            end
`else
            // Fixed priority: lowest requesting master index wins.
            always_comb begin
                win_any = 1'b0;
                win_idx = '0;
                for (int m = N_MST - 1; m >= 0; m--) begin
                    if (req_vec[m]) begin
                        win_any = 1'b1;
                        win_idx = MW'(m);
                    end
                end
            end
`endif

            always_comb begin
                win_oh = '0;
                if (win_any) begin
                    win_oh[win_idx] = 1'b1;
                end
            end

            assign slv_gnt[gi*N_MST +: N_MST] = win_oh;

            // An idle slave sees all-zero request fields, not a stale master.
            assign o_s_addr[gi*32 +: 32] = win_any ? i_m_addr[32*win_idx +: 32] : '0;
            assign o_s_size[gi*4 +: 4]   = win_any ? i_m_size[4*win_idx +: 4]   : '0;
            assign o_s_din[gi*DW +: DW]  = win_any ? i_m_din[DW*win_idx +: DW]  : '0;
            assign o_s_write[gi]         = win_any & i_m_write[win_idx];
            assign o_s_read[gi]          = win_any & i_m_read[win_idx];
        end
    endgenerate

    // Unmapped requests are granted immediately; mapped ones via their slave.
    always_comb begin
        o_m_gnt = '0;
        for (int m = 0; m < N_MST; m++) begin
            o_m_gnt[m] = i_m_req[m] & ~m_mapped[m];
            for (int s = 0; s < N_SLV; s++) begin
                o_m_gnt[m] = o_m_gnt[m] | slv_gnt[s*N_MST + m];
            end
        end
    end

    // Per-master response register {pending read, slave index, err}.
    generate
        for (gi = 0; gi < N_MST; gi++) begin : g_rsp
            logic          acc;
            logic          pend_reg;
            logic          err_reg;
            logic [SW-1:0] idx_reg;

            assign acc = i_m_req[gi] & o_m_gnt[gi];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    pend_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    idx_reg  <= '0;
                end else begin
                    pend_reg <= acc & i_m_read[gi];
                    err_reg  <= acc & ~m_mapped[gi];
                    idx_reg  <= m_slv[gi];
                end
            end

            assign o_m_rvalid[gi] = pend_reg;
            assign o_m_err[gi]    = err_reg;
            // Unmapped reads return zero data; no valid means zero data.
            assign o_m_dout[gi*DW +: DW] = (pend_reg & ~err_reg) ?
                                           i_s_dout[DW*idx_reg +: DW] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_ids_bus_xbar.sv
module tb_ids_bus_xbar;
    localparam int NM = 2;
    localparam int NS = 3;
    localparam int DW = 32;
    localparam logic [4*NS-1:0] TAGS = {4'h4, 4'h8, 4'h0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NM-1:0]    m_req, m_gnt, m_write, m_read, m_rvalid, m_err;
    logic [NM*32-1:0] m_addr;
    logic [NM*4-1:0]  m_size;
    logic [NM*DW-1:0] m_din, m_dout;
    logic [NS*32-1:0] s_addr;
    logic [NS-1:0]    s_write, s_read;
    logic [NS*4-1:0]  s_size;
    logic [NS*DW-1:0] s_din, s_dout;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: expected response per master, RR pointers.
    bit exp_pend [NM];
    bit exp_err  [NM];
    int exp_slv  [NM];
    int ptr      [NS];

    always #5 clk = ~clk;

    ids_bus_xbar #(.N_MST(NM), .N_SLV(NS), .DW(DW), .SLV_TAG(TAGS)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m_req(m_req), .o_m_gnt(m_gnt), .i_m_addr(m_addr),
        .i_m_write(m_write), .i_m_read(m_read), .i_m_size(m_size),
        .i_m_din(m_din), .o_m_dout(m_dout), .o_m_rvalid(m_rvalid),
        .o_m_err(m_err), .o_s_addr(s_addr), .o_s_write(s_write),
        .o_s_read(s_read), .o_s_size(s_size), .o_s_din(s_din),
        .i_s_dout(s_dout)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(logic [31:0] a);
        logic [4*NS-1:0] t;
        t = TAGS;
        for (int s = 0; s < NS; s++) begin
            if (t[s*4 +: 4] == a[31:28]) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            exp_pend[m] = 0; exp_err[m] = 0; exp_slv[m] = 0;
        end
        for (int s = 0; s < NS; s++) ptr[s] = 0;
    endtask

    task automatic idle();
        m_req = '0; m_write = '0; m_read = '0;
        m_addr = '0; m_size = '0; m_din = '0;
    endtask

    task automatic set_m(int m, bit rd, bit wr, logic [31:0] a);
        m_req[m] = 1'b1; m_read[m] = rd; m_write[m] = wr;
        m_addr[m*32 +: 32] = a;
        m_size[m*4 +: 4] = 4'hF;
        m_din[m*DW +: DW] = $urandom;
    endtask

    // One bus cycle: inputs already driven. Checks responses to the previous
    // cycle and this cycle's grants/slave side, then advances the model.
    task automatic step(output logic [NM-1:0] g, output logic [NM-1:0] rv,
                        output logic [NM-1:0] er, output logic [NM*DW-1:0] dd);
        int tgt [NM];
        int win [NS];
        logic [NM-1:0] eg;
        #1;
        g = m_gnt; rv = m_rvalid; er = m_err; dd = m_dout;
        for (int m = 0; m < NM; m++) begin
            logic [DW-1:0] ed;
            ed = '0;
            if (exp_pend[m] && !exp_err[m]) ed = s_dout[exp_slv[m]*DW +: DW];
            check($sformatf("rvalid[%0d]", m), m_rvalid[m], exp_pend[m]);
            check($sformatf("err[%0d]", m), m_err[m], exp_err[m]);
            check($sformatf("dout[%0d]", m), m_dout[m*DW +: DW], ed);
        end
        for (int m = 0; m < NM; m++) tgt[m] = decode(m_addr[m*32 +: 32]);
        eg = '0;
        for (int s = 0; s < NS; s++) begin
            win[s] = -1;
            for (int k = 0; k < NM; k++) begin
                int m;
`ifdef IDS_BUS_XBAR_RR_EN
                m = (ptr[s] + k) % NM;
`else
                m = k;
`endif
                if (win[s] < 0 && m_req[m] && tgt[m] == s) win[s] = m;
            end
            if (win[s] >= 0) begin
                eg[win[s]] = 1'b1;
                check($sformatf("s_addr[%0d]", s), s_addr[s*32 +: 32], m_addr[win[s]*32 +: 32]);
                check($sformatf("s_size[%0d]", s), s_size[s*4 +: 4], m_size[win[s]*4 +: 4]);
                check($sformatf("s_din[%0d]", s), s_din[s*DW +: DW], m_din[win[s]*DW +: DW]);
                check($sformatf("s_read[%0d]", s), s_read[s], m_read[win[s]]);
                check($sformatf("s_write[%0d]", s), s_write[s], m_write[win[s]]);
                ptr[s] = (win[s] + 1) % NM;
            end else begin
                check($sformatf("s_addr[%0d]", s), s_addr[s*32 +: 32], 0);
                check($sformatf("s_size[%0d]", s), s_size[s*4 +: 4], 0);
                check($sformatf("s_din[%0d]", s), s_din[s*DW +: DW], 0);
                check($sformatf("s_read[%0d]", s), s_read[s], 0);
                check($sformatf("s_write[%0d]", s), s_write[s], 0);
            end
        end
        for (int m = 0; m < NM; m++) begin
            if (m_req[m] && tgt[m] < 0) eg[m] = 1'b1;
            check($sformatf("gnt[%0d]", m), m_gnt[m], eg[m]);
            exp_pend[m] = m_req[m] && eg[m] && m_read[m];
            exp_err[m]  = m_req[m] && eg[m] && (tgt[m] < 0);
            exp_slv[m]  = (tgt[m] < 0) ? 0 : tgt[m];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NM-1:0] g, rv, er;
        logic [NM*DW-1:0] dd;
        logic [3:0] nib [5];
        nib[0] = 4'h0; nib[1] = 4'h4; nib[2] = 4'h8; nib[3] = 4'h2; nib[4] = 4'hF;

        idle();
        s_dout = {$urandom, $urandom, $urandom};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rvalid", m_rvalid, 0);
        check("reset_err", m_err, 0);
        check("reset_dout", m_dout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both masters write the same slave for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            idle();
            set_m(0, 0, 1, 32'h0000_1000);
            set_m(1, 0, 1, 32'h0000_1000);
            step(g, rv, er, dd);
`ifdef IDS_BUS_XBAR_RR_EN
            check($sformatf("contend_gnt_%0d", i), g, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
            check($sformatf("contend_gnt_%0d", i), g, 2'b01);
`endif
        end

        // Parallel reads to different slaves.
        idle();
        set_m(0, 1, 0, 32'h0000_1004);
        set_m(1, 1, 0, 32'h8000_0000);
        step(g, rv, er, dd);
        check("par_gnt", g, 2'b11);
        idle();
        s_dout = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        step(g, rv, er, dd);
        check("par_rvalid", rv, 2'b11);
        check("par_dout0", dd[0 +: DW], 32'h1111_1111);
        check("par_dout1", dd[DW +: DW], 32'h2222_2222);

        // Unmapped read.
        idle();
        set_m(1, 1, 0, 32'h2000_0000);
        step(g, rv, er, dd);
        check("unm_gnt", g[1], 1);
        idle();
        step(g, rv, er, dd);
        check("unm_rvalid", rv[1], 1);
        check("unm_err", er[1], 1);
        check("unm_dout", dd[DW +: DW], 0);

        // Back-to-back reads.
        idle();
        set_m(0, 1, 0, 32'h0000_1000);
        step(g, rv, er, dd);
        idle();
        set_m(0, 1, 0, 32'h0000_1004);
        s_dout[0 +: DW] = 32'hA5A5_0001;
        step(g, rv, er, dd);
        check("b2b_rv0", rv[0], 1);
        check("b2b_d0", dd[0 +: DW], 32'hA5A5_0001);
        idle();
        s_dout[0 +: DW] = 32'hA5A5_0002;
        step(g, rv, er, dd);
        check("b2b_rv1", rv[0], 1);
        check("b2b_d1", dd[0 +: DW], 32'hA5A5_0002);

        // Read granted, then reset asserted the following cycle.
        idle();
        set_m(0, 1, 0, 32'h0000_1000);
        step(g, rv, er, dd);
        idle();
        rst_n = 1'b0;
        #1;
        check("rst_rvalid", m_rvalid, 0);
        check("rst_err", m_err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // First cycle after release: pointers back at 0, so M0 wins.
        set_m(0, 0, 1, 32'h0000_0000);
        set_m(1, 0, 1, 32'h0000_0000);
        step(g, rv, er, dd);
        check("post_rst_gnt", g, 2'b01);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            m_req = NM'($urandom);
            m_read = NM'($urandom);
            m_write = NM'($urandom);
            for (int m = 0; m < NM; m++) begin
                m_addr[m*32 +: 32] = {nib[$urandom_range(4, 0)], 28'($urandom)};
                m_size[m*4 +: 4] = 4'($urandom);
                m_din[m*DW +: DW] = $urandom;
            end
            for (int s = 0; s < NS; s++) s_dout[s*DW +: DW] = $urandom;
            step(g, rv, er, dd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
